// File: rtl/bitwise_logic_accum.sv
// Registered bitwise logic unit (AND/OR/XOR/XNOR) with a framed running-XOR
// checksum, saturating word counter and one-cycle done/error pulses.
module bitwise_logic_accum #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   x,
    output logic               out_valid,
    output logic               parity,
    output logic [WIDTH-1:0]   acc,
    output logic [COUNT_W-1:0] word_cnt,
    output logic               acc_done,
    output logic               frame_err
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   r;
    logic [WIDTH-1:0]   x_reg, x_next;
    logic               parity_reg, parity_next;
    logic               out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [COUNT_W-1:0] word_cnt_reg, word_cnt_next;
    logic [COUNT_W-1:0] word_cnt_inc;
    logic               acc_done_reg, acc_done_next;
    logic               frame_err_reg, frame_err_next;

    // op[1] selects the XOR family; op[0] then inverts it to give XNOR.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign r[gi] = op[1] ? (a[gi] ^ b[gi] ^ op[0])
                                 : (op[0] ? (a[gi] | b[gi]) : (a[gi] & b[gi]));
        end
    endgenerate

    assign word_cnt_inc = (word_cnt_reg == CNT_MAX) ? word_cnt_reg
                                                    : word_cnt_reg + CNT_ONE;

    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        parity_next    = parity_reg;
        out_valid_next = in_valid;
        acc_next       = acc_reg;
        word_cnt_next  = word_cnt_reg;
        acc_done_next  = 1'b0;
        frame_err_next = 1'b0;

        if (in_valid) begin
            x_next      = r;
            parity_next = ^r;
            unique case (state_reg)
                IDLE: begin
                    if (in_first) begin
                        acc_next      = r;
                        word_cnt_next = CNT_ONE;
                        if (in_last) begin
                            acc_done_next = 1'b1;
                        end else begin
                            state_next = ACC;
                        end
                    end else if (in_last) begin
                        frame_err_next = 1'b1;
                    end
                end
                ACC: begin
                    if (in_first) begin
                        // A new first word mid-frame restarts the checksum.
                        frame_err_next = 1'b1;
                        acc_next       = r;
                        word_cnt_next  = CNT_ONE;
                    end else begin
                        acc_next      = acc_reg ^ r;
                        word_cnt_next = word_cnt_inc;
                    end
                    if (in_last) begin
                        acc_done_next = 1'b1;
                        state_next    = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            parity_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            word_cnt_reg  <= '0;
            acc_done_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            parity_reg    <= parity_next;
            out_valid_reg <= out_valid_next;
            acc_reg       <= acc_next;
            word_cnt_reg  <= word_cnt_next;
            acc_done_reg  <= acc_done_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign x         = x_reg;
    assign parity    = parity_reg;
    assign out_valid = out_valid_reg;
    assign acc       = acc_reg;
    assign word_cnt  = word_cnt_reg;
    assign acc_done  = acc_done_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_bitwise_logic_accum.sv
// Scoreboard bench: two instances (COUNT_W=8 and COUNT_W=2) share stimulus;
// a frame-level reference model predicts every cycle's outputs.
module tb_bitwise_logic_accum;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid, in_first, in_last;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;

    logic [WIDTH-1:0] x0, acc0, x1, acc1;
    logic [7:0]       cnt0;
    logic [1:0]       cnt1;
    logic             ov0, par0, done0, err0;
    logic             ov1, par1, done1, err1;

    bitwise_logic_accum #(.WIDTH(WIDTH), .COUNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .op(op), .a(a), .b(b), .x(x0), .out_valid(ov0),
        .parity(par0), .acc(acc0), .word_cnt(cnt0), .acc_done(done0),
        .frame_err(err0)
    );

    bitwise_logic_accum #(.WIDTH(WIDTH), .COUNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .op(op), .a(a), .b(b), .x(x1), .out_valid(ov1),
        .parity(par1), .acc(acc1), .word_cnt(cnt1), .acc_done(done1),
        .frame_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int par;
        int ov;
        int acc;
        int cnt;
        int done;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: count is unbounded, each DUT sees it clamped.
    int m_x, m_par, m_ov, m_acc, m_cnt, m_done, m_err;
    bit m_in_frame;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic int op_result(input int o, input int aa, input int bb);
        case (o)
            0:       return aa & bb;
            1:       return aa | bb;
            2:       return aa ^ bb;
            default: return (~(aa ^ bb)) & 15;
        endcase
    endfunction

    task automatic drive(input bit r_, input bit v, input bit f, input bit l,
                         input int o, input int aa, input int bb);
        int   res;
        exp_t e;
        @(negedge clk);
        rst = r_; in_valid = v; in_first = f; in_last = l;
        op = 2'(o); a = 4'(aa); b = 4'(bb);
        res = op_result(o, aa, bb);
        if (r_) begin
            m_x = 0; m_par = 0; m_ov = 0; m_acc = 0; m_cnt = 0;
            m_done = 0; m_err = 0; m_in_frame = 0;
        end else begin
            m_done = 0; m_err = 0; m_ov = v;
            if (v) begin
                m_x   = res;
                m_par = $countones(res) % 2;
                if (f) begin
                    if (m_in_frame) m_err = 1;
                    m_acc = res; m_cnt = 1;
                    m_in_frame = !l;
                    if (l) m_done = 1;
                end else if (m_in_frame) begin
                    m_acc = m_acc ^ res; m_cnt = m_cnt + 1;
                    if (l) begin m_done = 1; m_in_frame = 0; end
                end else if (l) begin
                    m_err = 1;
                end
            end
        end
        e.x = m_x; e.par = m_par; e.ov = m_ov; e.acc = m_acc;
        e.cnt = m_cnt; e.done = m_done; e.err = m_err;
        $display("txn t=%0t rst=%0b v=%0b f=%0b l=%0b op=%0d a=%h b=%h -> x=%h acc=%h cnt=%0d done=%0d err=%0d",
                 $time, r_, v, f, l, o, aa, bb, e.x, e.acc, e.cnt, e.done, e.err);
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so each pushed record appears after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("x",          int'(x0),    e.x);
                check("parity",     int'(par0),  e.par);
                check("out_valid",  int'(ov0),   e.ov);
                check("acc",        int'(acc0),  e.acc);
                check("word_cnt8",  int'(cnt0),  (e.cnt > 255) ? 255 : e.cnt);
                check("acc_done",   int'(done0), e.done);
                check("frame_err",  int'(err0),  e.err);
                check("x_c2",       int'(x1),    e.x);
                check("acc_c2",     int'(acc1),  e.acc);
                check("word_cnt2",  int'(cnt1),  (e.cnt > 3) ? 3 : e.cnt);
                check("acc_done_c2",int'(done1), e.done);
                check("frame_err_c2",int'(err1), e.err);
                check("out_valid_c2",int'(ov1),  e.ov);
                check("parity_c2",  int'(par1),  e.par);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        op = 2'd0; a = '0; b = '0;
        m_x = 0; m_par = 0; m_ov = 0; m_acc = 0; m_cnt = 0;
        m_done = 0; m_err = 0; m_in_frame = 0;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // All four ops on the same operands, then idle.
        for (int o = 0; o < 4; o++) drive(0, 1, 0, 0, o, 4'b1100, 4'b1010);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Three-word XOR frame.
        drive(0, 1, 1, 0, 2, 4'b1100, 4'b1010);
        drive(0, 1, 0, 0, 2, 4'b0001, 4'b0010);
        drive(0, 1, 0, 1, 2, 4'b1111, 4'b0000);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Single-word frame.
        drive(0, 1, 1, 1, 0, 4'b0101, 4'b0011);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Mid-frame restart then close.
        drive(0, 1, 1, 0, 2, 4'b0011, 4'b0101);
        drive(0, 1, 0, 0, 2, 4'b1000, 4'b0001);
        drive(0, 1, 1, 0, 2, 4'b0111, 4'b0000);
        drive(0, 1, 0, 1, 2, 4'b0001, 4'b0000);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Six-word frame saturates the 2-bit counter.
        for (int i = 0; i < 6; i++)
            drive(0, 1, i == 0, i == 5, 2, $urandom_range(0, 15), $urandom_range(0, 15));
        drive(0, 0, 0, 0, 0, 0, 0);

        // Last without first while idle.
        drive(0, 1, 0, 1, 1, 4'b0110, 4'b0001);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset mid-frame, then a clean frame.
        drive(0, 1, 1, 0, 2, 4'b1010, 4'b0101);
        drive(0, 1, 0, 0, 2, 4'b0011, 4'b0000);
        drive(1, 1, 0, 1, 2, 4'b1111, 4'b0001);
        drive(0, 1, 1, 0, 3, 4'b0100, 4'b0010);
        drive(0, 1, 0, 1, 3, 4'b1001, 4'b1001);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_accum.md
Name: bitwise_logic_accum

Overview:
Parametrised successor to the fixed 4-bit XOR gate block. Computes a selectable bitwise function (AND/OR/XOR/XNOR) of two WIDTH-bit operands and registers the result. Folds results into a framed running-XOR checksum with word count and frame-error detection. Sits in the basic-gates lab datapath as the registered, streaming logic unit feeding checksum/parity consumers.

Parameters:
WIDTH, 4, operand/result width in bits (>=1)
COUNT_W, 8, width of frame word counter (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands/op valid this cycle
in_first  input  1  word is first of a frame (qualified by in_valid)
in_last  input  1  word is last of a frame (qualified by in_valid)
op  input  2  00 AND, 01 OR, 10 XOR, 11 XNOR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
x  output  WIDTH  registered per-word result
out_valid  output  1  x updated this cycle
parity  output  1  reduction XOR of x
acc  output  WIDTH  running XOR checksum of frame results
word_cnt  output  COUNT_W  words accumulated in current/last frame
acc_done  output  1  one-cycle pulse: frame complete, acc/word_cnt final
frame_err  output  1  one-cycle pulse: framing violation

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. Reset dominates all inputs.
- Reset: x=0, out_valid=0, parity=0, acc=0, word_cnt=0, acc_done=0, frame_err=0, state=IDLE.
- r = op(a,b) combinational; all outputs are registered; latency 1 cycle.
- Per word: in_valid=1 -> next cycle x<=r, parity<=^r, out_valid<=1. in_valid=0 -> out_valid<=0, x/parity hold. Holds in every state, independent of framing.
- in_first/in_last are ignored when in_valid=0.
- States: IDLE, ACC.
- IDLE, in_valid&in_first: acc<=r, word_cnt<=1. If in_last also set (single-word frame): acc_done<=1, stay IDLE. Otherwise go to ACC.
- IDLE, in_valid&!in_first: no accumulation; acc/word_cnt hold. If in_last: frame_err<=1.
- ACC, in_valid&!in_first: acc<=acc^r, word_cnt<=word_cnt+1, saturating at 2^COUNT_W-1 (acc keeps folding after saturation). If in_last: acc_done<=1, go to IDLE.
- ACC, in_valid&in_first: frame_err<=1. Restart: acc<=r, word_cnt<=1. If in_last also set: acc_done<=1, go to IDLE. Otherwise stay in ACC.
- ACC, in_valid=0: hold.
- acc_done and frame_err are high for exactly one cycle; otherwise 0.
- After acc_done, acc/word_cnt hold their final values until the next in_first.
- Reset mid-frame: frame discarded, all outputs zero next cycle, no acc_done.

Test Plan:
1. WIDTH=4, a=1100, b=1010, op=00/01/10/11 on consecutive cycles -> x=1000/1110/0110/1001 one cycle later each; parity=1/1/0/0; out_valid high 4 cycles then low.
2. Frame of 3 words, op=XOR: (a,b)=(1100,1010),(0001,0010),(1111,0000) with first on word 1, last on word 3 -> acc=1010, word_cnt=3, acc_done single pulse in the cycle after word 3; state IDLE.
3. Single word, first&last, a=0101, b=0011, op=AND -> acc=0001, word_cnt=1, acc_done pulse, frame_err=0.
4. Mid-frame restart: 2 words in ACC, then in_first with r=0111 (no last) -> frame_err pulse, acc=0111, word_cnt=1; then a last word r=0001 -> acc=0110, word_cnt=2, acc_done pulse.
5. COUNT_W=2: 6-word XOR frame -> word_cnt saturates at 3; acc equals the XOR of all 6 results. Separately, in_last without first in IDLE -> frame_err pulse, acc unchanged.
6. Assert rst for 1 cycle mid-frame alongside in_valid&in_last -> all outputs 0 next cycle, no acc_done; a following in_first starts a clean frame.
